freq_meas_scheduler: RTL

Time-multiplexes one edge counter across NUM_CH asynchronous measured signals to give a round-robin multi-channel frequency meter in a single clock domain. For each enabled channel it runs a settle phase, then a fixed gate window that counts rising edges. It then publishes the count tagged with the channel index and moves to the next enabled channel. Downstream logic converts count/GATE_CYCLES to frequency.

---
 rtl/freq_meas_scheduler_if.sv | 21 ++
 rtl/freq_meas_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/freq_meas_scheduler_if.sv
// rtl/freq_meas_scheduler_if.sv - result bus between the frequency scheduler and its consumer
// Purpose: groups the published measurement and the activity flag.
// Ports (master drives, slave observes):
//   result       edge count of the last published gate
//   result_ch    channel index the result belongs to
//   result_valid one-cycle strobe qualifying result/result_ch/result_ovf
//   result_ovf   counter saturated during that gate
//   busy         a measurement is in progress
interface freq_meas_scheduler_if #(
  parameter int CH_W      = 2,
  parameter int CNTR_SIZE = 10
);
  logic [CNTR_SIZE-1:0] result;
  logic [CH_W-1:0]      result_ch;
  logic                 result_valid;
  logic                 result_ovf;
  logic                 busy;

  modport master (output result, result_ch, result_valid, result_ovf, busy);
  modport slave  (input  result, result_ch, result_valid, result_ovf, busy);
endinterface

// File: rtl/freq_meas_scheduler.sv
// rtl/freq_meas_scheduler.sv - round-robin multi-channel frequency meter sharing one edge counter
// Purpose: for each enabled channel run SETTLE, count synchronized rising edges over a
//   GATE_CYCLES window, then publish the count tagged with the channel index.
// Ports:
//   clk      system clock, posedge
//   rst      asynchronous active-low reset
//   en       run enable; low aborts the current measurement and idles
//   ch_mask  channels participating in the rotation (sampled at selection only)
//   meas_in  asynchronous measured signals
//   res      result bus (master side)
module freq_meas_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 2,
  parameter int CNTR_SIZE     = 10,
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic [NUM_CH-1:0]    meas_in,
  freq_meas_scheduler_if.master res
);

  localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, PUBLISH} state_t;

  state_t               state;
  logic [CH_W-1:0]      sel;
  logic [CNTR_SIZE-1:0] cntr;
  logic                 ovf;
  logic [TW-1:0]        timer;
  logic [NUM_CH-1:0]    sync1;
  logic [NUM_CH-1:0]    sync2;
  logic                 prev;
  logic                 rise;

  assign rise = sync2[sel] & ~prev;

  // First set mask bit scanning upward from start, wrapping. With strict set the
  // scan begins one past start and ends on start itself, so a single-bit mask
  // keeps re-selecting the same channel.
  function automatic logic [CH_W-1:0] pick(input logic [NUM_CH-1:0] mask,
                                           input logic [CH_W-1:0]   start,
                                           input logic              strict);
    logic [CH_W-1:0] r;
    int              lo;
    int              idx;
    r  = start;
    lo = strict ? 1 : 0;
    // Scan downward so the lowest qualifying offset is the last one written.
    for (int off = NUM_CH; off >= 0; off--) begin
      idx = (int'(start) + off) % NUM_CH;
      if (off >= lo && off <= lo + NUM_CH - 1 && mask[idx[CH_W-1:0]])
        r = idx[CH_W-1:0];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      sel              <= '0;
      cntr             <= '0;
      ovf              <= 1'b0;
      timer            <= '0;
      sync1            <= '0;
      sync2            <= '0;
      prev             <= 1'b0;
      res.result       <= '0;
      res.result_ch    <= '0;
      res.result_valid <= 1'b0;
      res.result_ovf   <= 1'b0;
      res.busy         <= 1'b0;
    end else begin
      sync1            <= meas_in;
      sync2            <= sync1;
      // Tracking the selected channel every cycle means SETTLE always primes
      // prev with the new channel's level, so a switch never looks like an edge.
      prev             <= sync2[sel];
      res.result_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (en && (|ch_mask)) begin
            sel      <= pick(ch_mask, sel, 1'b0);
            timer    <= TW'(SETTLE_CYCLES - 1);
            state    <= SETTLE;
            res.busy <= 1'b1;
          end
        end

        SETTLE: begin
          cntr <= '0;
          ovf  <= 1'b0;
          if (!en) begin
            state    <= IDLE;
            res.busy <= 1'b0;
          end else if (timer == '0) begin
            timer <= TW'(GATE_CYCLES - 1);
            state <= GATE;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        GATE: begin
          if (!en) begin
            state    <= IDLE;
            res.busy <= 1'b0;
          end else begin
            if (rise) begin
              if (&cntr) ovf  <= 1'b1;
              else       cntr <= cntr + CNTR_SIZE'(1);
            end
            if (timer == '0) state <= PUBLISH;
            else             timer <= timer - TW'(1);
          end
        end

        PUBLISH: begin
          if (!en) begin
            state    <= IDLE;
            res.busy <= 1'b0;
          end else begin
            res.result       <= cntr;
            res.result_ch    <= sel;
            res.result_ovf   <= ovf;
            res.result_valid <= 1'b1;
            if (|ch_mask) begin
              sel   <= pick(ch_mask, sel, 1'b1);
              timer <= TW'(SETTLE_CYCLES - 1);
              state <= SETTLE;
            end else begin
              state    <= IDLE;
              res.busy <= 1'b0;
            end
          end
        end

        default: begin
          state    <= IDLE;
          res.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
